button_conditioner: RTL and testbench

//  Upstream input stage of the vending machine. It conditions the raw board buttons: buy, quarter, dollar, and any later additions.
//  - 2-FF synchronizer, then a counter-based debouncer per channel.
//  - Rising-edge detection turns each debounced press into a single-cycle pulse.
//  - A fixed-priority serializer guarantees at most one pulse per cycle.

---
 rtl/button_conditioner_pkg.sv | 8 +
 rtl/button_conditioner_if.sv | 9 +
 rtl/button_conditioner_btn_debounce_ch.sv | 26 ++
 rtl/button_conditioner.sv | 43 ++++
 tb/tb_button_conditioner.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared vending channel indices and debounce defaults
package button_conditioner_pkg;
  localparam int BTN_BUY = 0;
  localparam int BTN_QUARTER = 1;
  localparam int BTN_DOLLAR = 2;
  localparam int N_BTN_DEFAULT = 3;
  localparam int DB_CYCLES_DEFAULT = 1000000;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw buttons in, debounced levels and press pulses out
interface button_conditioner_if #(parameter int N_BTN = 3);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic busy;
  modport master (output btn_raw, input btn_level, btn_pulse, busy);
  modport slave (input btn_raw, output btn_level, btn_pulse, busy);
endinterface

// File: rtl/button_conditioner_btn_debounce_ch.sv
// btn_debounce_ch: two-flop synchronizer plus counter debouncer for one button
module btn_debounce_ch #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [1:0] sync_ff;
  logic [CW-1:0] cnt;
  logic done;
  assign done = (sync_ff[1] != stable) && (cnt == CW'(DB_CYCLES - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
      cnt <= '0;
      stable <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      cnt <= (sync_ff[1] == stable || done) ? '0 : cnt + 1'b1;
      stable <= done ? sync_ff[1] : stable;
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced buttons turned into serialized one-cycle press pulses
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input logic clk,
  input logic rst,
  button_conditioner_if.slave bus
);
  logic [N_BTN-1:0] stable, stable_d, pending, grant, pending_nxt;
  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
        .clk(clk),
        .rst(rst),
        .raw(bus.btn_raw[i]),
        .stable(stable[i])
      );
    end
  endgenerate
  assign bus.btn_level = stable;
  // lowest set bit wins; a new rise overrides a same-cycle clear
  always_comb begin
    grant = pending & (-pending);
    pending_nxt = (pending & ~grant) | (stable & ~stable_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '0;
      pending <= '0;
      bus.btn_pulse <= '0;
      bus.busy <= 1'b0;
    end else begin
      stable_d <= stable;
      pending <= pending_nxt;
      bus.btn_pulse <= grant;
      bus.busy <= |pending_nxt;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random presses against a sliding-window reference model
module tb_button_conditioner;
  localparam int N = 3;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int edge_no;
  int first_edge[N];
  int npulse[N];
  int hold[N];
  button_conditioner_if #(.N_BTN(N)) bus ();
  button_conditioner #(.N_BTN(N), .DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [N-1:0] m_r1, m_r2, m_level, m_pend, m_pulse, m_rise, m_nl;
  logic m_busy;
  logic [DB-1:0] hist[N];
  int k;
  // level flips once the last DB synchronized samples all disagree with it
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r1 = '0; m_r2 = '0; m_level = '0; m_pend = '0; m_pulse = '0; m_rise = '0; m_busy = 1'b0;
      for (int i = 0; i < N; i++) hist[i] = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        hist[i] = {hist[i][DB-2:0], m_r2[i]};
        m_nl[i] = m_level[i] ? (hist[i] != '0) : (&hist[i]);
      end
      k = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) k = i;
      m_pulse = (k >= 0) ? N'(1 << k) : '0;
      m_pend = (m_pend & ~m_pulse) | m_rise;
      m_busy = |m_pend;
      m_rise = m_nl & ~m_level;
      m_level = m_nl;
      m_r2 = m_r1;
      m_r1 = bus.btn_raw;
    end
  end
  task automatic check(string tag);
    tests++;
    assert ({bus.btn_level, bus.btn_pulse, bus.busy} === {m_level, m_pulse, m_busy})
    else begin
      fails++;
      $error("FAIL %s edge %0d: level/pulse/busy got %b/%b/%b exp %b/%b/%b", tag, edge_no,
             bus.btn_level, bus.btn_pulse, bus.busy, m_level, m_pulse, m_busy);
    end
  endtask
  task automatic clr();
    edge_no = 0;
    for (int i = 0; i < N; i++) begin first_edge[i] = -1; npulse[i] = 0; end
  endtask
  task automatic tick(string tag);
    @(posedge clk);
    @(negedge clk);
    edge_no++;
    for (int i = 0; i < N; i++) if (bus.btn_pulse[i]) begin
      npulse[i]++;
      if (first_edge[i] < 0) first_edge[i] = edge_no;
    end
    check(tag);
  endtask
  task automatic run(int n, string tag);
    for (int c = 0; c < n; c++) tick(tag);
  endtask
  task automatic expect_int(string tag, int got, int exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  initial begin
    bus.btn_raw = '0;
    #12;
    check("reset");
    @(negedge clk);
    rst = 1'b0;
    run(10, "idle");
    clr();
    bus.btn_raw = 3'b010;
    run(20, "press1");
    expect_int("press1_edge", first_edge[1], 8);
    expect_int("press1_count", npulse[1], 1);
    clr();
    bus.btn_raw = 3'b000;
    run(12, "release1");
    expect_int("release1_count", npulse[1], 0);
    clr();
    for (int c = 0; c < 6; c++) begin
      bus.btn_raw[0] = ~bus.btn_raw[0];
      run(2, "bounce");
    end
    bus.btn_raw[0] = 1'b1;
    clr();
    run(15, "bounce_hold");
    expect_int("bounce_edge", first_edge[0], 8);
    expect_int("bounce_count", npulse[0], 1);
    bus.btn_raw = 3'b000;
    run(10, "bounce_rel");
    clr();
    bus.btn_raw[2] = 1'b1;
    run(3, "glitch");
    bus.btn_raw[2] = 1'b0;
    run(10, "glitch_low");
    expect_int("glitch_count", npulse[2], 0);
    clr();
    bus.btn_raw = 3'b101;
    run(14, "dual");
    expect_int("dual_edge0", first_edge[0], 8);
    expect_int("dual_edge2", first_edge[2], 9);
    bus.btn_raw = 3'b000;
    run(10, "dual_rel");
    clr();
    bus.btn_raw = 3'b111;
    run(14, "triple");
    expect_int("triple_edge0", first_edge[0], 8);
    expect_int("triple_edge1", first_edge[1], 9);
    expect_int("triple_edge2", first_edge[2], 10);
    bus.btn_raw = 3'b000;
    run(10, "triple_rel");
    clr();
    bus.btn_raw = 3'b010;
    run(3, "rst_press");
    rst = 1'b1;
    #1;
    check("rst_async");
    run(1, "rst_hold");
    rst = 1'b0;
    clr();
    run(14, "rst_after");
    expect_int("rst_edge", first_edge[1], 8);
    expect_int("rst_count", npulse[1], 1);
    bus.btn_raw = 3'b000;
    run(10, "rst_rel");
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          bus.btn_raw[i] = $urandom_range(0, 1);
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
        end
        hold[i]--;
      end
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        run(1, "rand_rst");
        rst = 1'b0;
      end
      tick("random");
      tests++;
      assert ($countones(bus.btn_pulse) <= 1)
      else begin
        fails++;
        $error("FAIL onehot0 pulse got %b exp at most one bit", bus.btn_pulse);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
